// File: rtl/sipo_deser_8b.sv
// rtl/sipo_deser_8b.sv - serial-in/parallel-out receiver with single-entry output buffer (optional PARITY_EN)
module sipo_deser_8b #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_a,
  input  logic             i_sin,
  input  logic             i_sin_valid,
  input  logic             i_msb_first,
  input  logic             i_flush,
  input  logic             i_op_ready,
  output logic [WIDTH-1:0] o_op,
  output logic             o_op_valid,
  output logic             o_busy,
  output logic             o_overrun,
  output logic             o_parity_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
`ifdef PARITY_EN
    S_PARITY = 2'd3,
`endif
    S_WAIT   = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;
  logic             r_msb;
  logic [WIDTH-1:0] r_op;
  logic             r_op_valid;
  logic             r_overrun;

  logic             w_msb;
  logic [WIDTH-1:0] w_shifted;
  logic             w_buf_free;
  logic             w_complete;
  logic [WIDTH-1:0] w_word;

`ifdef PARITY_EN
  logic             r_parity_err;
  logic             r_pend_perr;
  logic             w_word_perr;
`endif

  // Bit order is frozen at the first bit; in IDLE the live input selects the direction.
  assign w_msb      = (r_state == S_IDLE) ? i_msb_first : r_msb;
  assign w_shifted  = w_msb ? {r_sr[WIDTH-2:0], i_sin} : {i_sin, r_sr[WIDTH-1:1]};
  assign w_buf_free = !r_op_valid || i_op_ready;

`ifdef PARITY_EN
  // Frame ends on the parity bit; the data word is already complete in the shift register.
  assign w_complete  = i_sin_valid && !i_flush && (r_state == S_PARITY);
  assign w_word      = r_sr;
  assign w_word_perr = (^r_sr) ^ i_sin;
`else
  // Frame ends on the last data bit; the word includes the bit arriving this cycle.
  assign w_complete  = i_sin_valid && !i_flush && (r_state == S_SHIFT) && (r_cnt == LAST_DATA);
  assign w_word      = w_shifted;
`endif

  // Frame collection, completion handoff, WAIT stall, flush and sticky overrun.
  always_ff @(posedge i_clk) begin
    if (i_rst_a) begin
      r_state    <= S_IDLE;
      r_sr       <= '0;
      r_cnt      <= '0;
      r_msb      <= 1'b0;
      r_op       <= '0;
      r_op_valid <= 1'b0;
      r_overrun  <= 1'b0;
`ifdef PARITY_EN
      r_parity_err <= 1'b0;
      r_pend_perr  <= 1'b0;
`endif
    end else begin
      // Consumer handshake; any load below overrides this and keeps op_valid high.
      if (r_op_valid && i_op_ready) begin
        r_op_valid <= 1'b0;
      end

      if (i_flush) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_sr    <= '0;
`ifdef PARITY_EN
        r_pend_perr <= 1'b0;
`endif
      end else if (w_complete) begin
        if (w_buf_free) begin
          r_op       <= w_word;
          r_op_valid <= 1'b1;
`ifdef PARITY_EN
          r_parity_err <= w_word_perr;
`endif
          r_state    <= S_IDLE;
          r_sr       <= '0;
        end else begin
          r_state <= S_WAIT;
          r_sr    <= w_word;
`ifdef PARITY_EN
          r_pend_perr <= w_word_perr;
`endif
        end
        r_cnt <= '0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (i_sin_valid) begin
              r_sr    <= w_shifted;
              r_cnt   <= CW'(1);
              r_msb   <= i_msb_first;
              r_state <= S_SHIFT;
            end
          end
          S_SHIFT: begin
            if (i_sin_valid) begin
              r_sr  <= w_shifted;
              r_cnt <= r_cnt + CW'(1);
`ifdef PARITY_EN
              if (r_cnt == LAST_DATA) begin
                r_state <= S_PARITY;
              end
`endif
            end
          end
`ifdef PARITY_EN
          S_PARITY: begin
            // Only reached with sin_valid low here; completion is handled above.
            r_state <= S_PARITY;
          end
`endif
          S_WAIT: begin
            if (i_sin_valid) begin
              r_overrun <= 1'b1;
            end
            if (i_op_ready) begin
              r_op       <= r_sr;
              r_op_valid <= 1'b1;
`ifdef PARITY_EN
              r_parity_err <= r_pend_perr;
`endif
              r_sr       <= '0;
              r_state    <= S_IDLE;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_op       = r_op;
  assign o_op_valid = r_op_valid;
  assign o_busy     = (r_state != S_IDLE);
  assign o_overrun  = r_overrun;
`ifdef PARITY_EN
  assign o_parity_err = r_parity_err;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deser_8b.sv
// tb/tb_sipo_deser_8b.sv - randomized and directed bench for sipo_deser_8b against a frame-level model
module tb_sipo_deser_8b;

  localparam int W = 8;
`ifdef PARITY_EN
  localparam int NB = W + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int NB = W;
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sin = 1'b0;
  logic         sin_valid = 1'b0;
  logic         msb_first = 1'b1;
  logic         flush = 1'b0;
  logic         op_ready = 1'b0;
  logic [W-1:0] op;
  logic         op_valid;
  logic         busy;
  logic         overrun;
  logic         parity_err;

  int n_checks = 0;
  int n_pass = 0;

  // reference model state
  bit           m_bits[$];
  bit           m_msb;
  logic [W-1:0] m_op;
  bit           m_opv;
  bit           m_ovr;
  bit           m_perr;
  bit           m_pend;
  logic [W-1:0] m_pend_word;
  bit           m_pend_perr;
  bit           perr_inject = 1'b0;

  sipo_deser_8b #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst_a(rst), .i_sin(sin), .i_sin_valid(sin_valid),
    .i_msb_first(msb_first), .i_flush(flush), .i_op_ready(op_ready),
    .o_op(op), .o_op_valid(op_valid), .o_busy(busy), .o_overrun(overrun),
    .o_parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Frame-level model: collect bits in a queue, assemble the word by arithmetic once the frame is full.
  task automatic model_step();
    bit loaded;
    int word;
    int ones;
    bit pe;
    loaded = 1'b0;
    if (rst) begin
      m_bits.delete();
      m_op = '0; m_opv = 0; m_ovr = 0; m_perr = 0; m_pend = 0;
      m_pend_word = '0; m_pend_perr = 0;
    end else begin
      if (flush) begin
        m_bits.delete();
        m_pend = 0;
      end else if (m_pend) begin
        if (sin_valid) m_ovr = 1;
        if (op_ready) begin
          m_op = m_pend_word; m_perr = m_pend_perr; m_opv = 1; m_pend = 0; loaded = 1;
        end
      end else if (sin_valid) begin
        if (m_bits.size() == 0) m_msb = msb_first;
        m_bits.push_back(sin);
        if (m_bits.size() == NB) begin
          word = 0; ones = 0;
          for (int i = 0; i < NB; i++) ones += int'(m_bits[i]);
          for (int i = 0; i < W; i++)
            if (m_bits[i]) word += m_msb ? (1 << (W - 1 - i)) : (1 << i);
          pe = PAR ? bit'(ones % 2) : 1'b0;
          m_bits.delete();
          if (!m_opv || op_ready) begin
            m_op = word[W-1:0]; m_perr = pe; m_opv = 1; loaded = 1;
          end else begin
            m_pend = 1; m_pend_word = word[W-1:0]; m_pend_perr = pe;
          end
        end
      end
      if (!loaded && m_opv && op_ready) m_opv = 0;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("op", op, m_op);
    check("op_valid", op_valid, m_opv);
    check("busy", busy, (m_bits.size() > 0) || m_pend);
    check("overrun", overrun, m_ovr);
    check("parity_err", parity_err, m_opv ? m_perr : parity_err);
  endtask

  task automatic send_bit(input bit b, input bit msb, input bit rdy);
    sin = b; sin_valid = 1; msb_first = msb; op_ready = rdy;
    step();
    sin_valid = 0;
  endtask

  task automatic send_frame(input logic [7:0] pat, input bit msb, input bit rdy, input bit gaps);
    for (int i = 0; i < W; i++) begin
      while (gaps && ($urandom % 2 == 1)) begin
        sin_valid = 0; op_ready = rdy; sin = 1'($urandom);
        step();
      end
      send_bit(pat[7 - i], msb, rdy);
    end
    if (PAR) send_bit((^pat) ^ perr_inject, msb, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      sin_valid = 0; op_ready = rdy;
      step();
    end
  endtask

  initial begin
    // reset
    rst = 1; idle(2, 0);
    rst = 0;
    check("rst_op", op, 0);
    check("rst_valid", op_valid, 0);
    check("rst_busy", busy, 0);

    // reset mid-frame, then a clean frame
    send_bit(1, 1, 1); send_bit(0, 1, 1); send_bit(1, 1, 1);
    check("mid_busy", busy, 1);
    rst = 1; idle(2, 1); rst = 0;
    check("midrst_op", op, 0);
    check("midrst_valid", op_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ovr", overrun, 0);

    // MSB-first B2 with op_ready high
    send_frame(8'hB2, 1, 1, 0);
    check("b2_op", op, 8'hB2);
    check("b2_valid", op_valid, 1);
    idle(1, 1);
    check("b2_consumed", op_valid, 0);
    check("b2_hold", op, 8'hB2);

    // LSB-first, same bits, random gaps
    send_frame(8'hB2, 0, 1, 1);
    check("4d_op", op, 8'h4D);
    check("4d_valid", op_valid, 1);
    idle(1, 1);

    // stall: second word waits, extra bit overruns, then drains
    send_frame(8'hB2, 1, 0, 0);
    check("st_b2", op, 8'hB2);
    send_frame(8'hB2, 0, 0, 0);
    check("st_wait_busy", busy, 1);
    check("st_wait_op", op, 8'hB2);
    send_bit(1, 1, 0);
    check("st_overrun", overrun, 1);
    check("st_op_kept", op, 8'hB2);
    idle(1, 1);
    check("st_drain_op", op, 8'h4D);
    check("st_drain_valid", op_valid, 1);
    check("st_drain_busy", busy, 0);
    idle(1, 1);
    rst = 1; idle(1, 0); rst = 0;

    // flush together with the third bit
    send_bit(0, 1, 1); send_bit(1, 1, 1);
    flush = 1; send_bit(1, 1, 1); flush = 0;
    check("fl_busy", busy, 0);
    check("fl_ovr", overrun, 0);
    send_frame(8'h3C, 1, 1, 0);
    check("fl_op", op, 8'h3C);
    check("fl_valid", op_valid, 1);
    check("fl_ovr2", overrun, 0);
    idle(1, 1);

`ifdef PARITY_EN
    // parity: valid only after the ninth bit, error flag from even parity
    for (int i = 0; i < W; i++) send_bit(1'((8'hB2 >> (7 - i)) & 1), 1, 1);
    check("par_not_yet", op_valid, 0);
    send_bit(1, 1, 1);
    check("par_valid", op_valid, 1);
    check("par_op", op, 8'hB2);
    check("par_err1", parity_err, 1);
    perr_inject = 0;
    send_frame(8'hB2, 1, 1, 0);
    check("par_err0", parity_err, 0);
    idle(1, 1);
`endif

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      sin       = 1'($urandom);
      sin_valid = ($urandom % 4) != 0;
      msb_first = 1'($urandom);
      op_ready  = ($urandom % 3) != 0;
      flush     = ($urandom % 60) == 0;
      rst       = ($urandom % 400) == 0;
      step();
    end
    rst = 0; flush = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
